// File: rtl/user_gpio_evt_pkg.sv
// Shared definitions for the user GPIO event plugin: register map and reset constants.
package user_gpio_evt_pkg;

    typedef enum logic [3:0] {
        REG_IN        = 4'd0,
        REG_OUT       = 4'd1,
        REG_OUT_SET   = 4'd2,
        REG_OUT_CLR   = 4'd3,
        REG_OUT_TGL   = 4'd4,
        REG_RISE_EN   = 4'd5,
        REG_FALL_EN   = 4'd6,
        REG_EVENT     = 4'd7,
        REG_IRQ_MASK  = 4'd8,
        REG_FILTER    = 4'd9,
        REG_PULSE_LEN = 4'd10
    } reg_idx_e;

    localparam int unsigned NR_REGS    = 11;
    localparam int unsigned FILTER_RST = 4;
    localparam int unsigned PULSE_RST  = 0;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/user_gpio_evt_filt.sv
// One GPIO input channel: two-flop synchroniser, glitch filter and registered edge detect.
module user_gpio_evt_filt #(
    parameter int unsigned FILT_W = 8
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              din,
    input  logic [FILT_W-1:0] filter_len,
    input  logic              rise_en,
    input  logic              fall_en,
    output logic              level,
    output logic              rise,
    output logic              fall
);

    logic              meta;
    logic              sync;
    logic [FILT_W-1:0] cnt_q;
    logic [FILT_W-1:0] cnt_d;
    logic              filt_d;

    // Level is accepted once sync has differed from it for filter_len+1 cycles.
    always_comb begin
        filt_d = level;
        cnt_d  = '0;
        if (sync != level) begin
            if (cnt_q >= filter_len) begin
                filt_d = sync;
            end else begin
                cnt_d = cnt_q + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            cnt_q <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= din;
            sync  <= meta;
            level <= filt_d;
            cnt_q <= cnt_d;
            rise  <= filt_d & ~level & rise_en;
            fall  <= ~filt_d & level & fall_en;
        end
    end

endmodule

// File: rtl/user_gpio_evt.sv
// Register-mapped GPIO plugin with filtered edge events, masked irq, atomic output ops and pulse mode.
module user_gpio_evt
    import user_gpio_evt_pkg::*;
#(
    parameter int unsigned NR_CH   = 48,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned FILT_W  = 8,
    parameter int unsigned PULSE_W = 16
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_wr,
    input  logic              bus_rd,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rd_valid,
    input  logic [NR_CH-1:0]  virtual_in,
    output logic [NR_CH-1:0]  virtual_out,
    output logic              irq
);

    localparam int unsigned NR_GRP = ceil_div(NR_CH, DATA_W);

    int unsigned       reg_num;
    int unsigned       grp;
    logic              reg_ok;
    reg_idx_e          reg_sel;
    logic              wr_out, wr_set, wr_clr, wr_tgl;
    logic              wr_rise, wr_fall, wr_event, wr_mask, wr_filter, wr_pulse;
    logic [NR_CH-1:0]  wvec, gmask, touch, bus_val, rd_vec;
    logic [NR_CH-1:0]  filt_vec, rise_vec, fall_vec, out_q;
    logic [NR_CH-1:0]  rise_en_q, fall_en_q, event_q, event_d, mask_q;
    logic [FILT_W-1:0] filter_q;
    logic [PULSE_W-1:0] pulse_len_q;
    logic [DATA_W-1:0] rd_bus, rd_scalar, rdata_c;

    // Word address splits into register index (major) and group (minor).
    always_comb begin
        reg_num   = 32'(bus_addr) / NR_GRP;
        grp       = 32'(bus_addr) % NR_GRP;
        reg_ok    = reg_num < NR_REGS;
        reg_sel   = reg_idx_e'(reg_num[3:0]);
        wr_out    = bus_wr && reg_ok && (reg_sel == REG_OUT);
        wr_set    = bus_wr && reg_ok && (reg_sel == REG_OUT_SET);
        wr_clr    = bus_wr && reg_ok && (reg_sel == REG_OUT_CLR);
        wr_tgl    = bus_wr && reg_ok && (reg_sel == REG_OUT_TGL);
        wr_rise   = bus_wr && reg_ok && (reg_sel == REG_RISE_EN);
        wr_fall   = bus_wr && reg_ok && (reg_sel == REG_FALL_EN);
        wr_event  = bus_wr && reg_ok && (reg_sel == REG_EVENT);
        wr_mask   = bus_wr && reg_ok && (reg_sel == REG_IRQ_MASK);
        wr_filter = bus_wr && reg_ok && (reg_sel == REG_FILTER) && (grp == 0);
        wr_pulse  = bus_wr && reg_ok && (reg_sel == REG_PULSE_LEN) && (grp == 0);
    end

    // Per-bit outcome of an output-register write; untouched bits keep running.
    always_comb begin
        touch   = '0;
        bus_val = out_q;
        if (wr_out) begin
            touch   = gmask;
            bus_val = wvec;
        end else if (wr_set) begin
            touch   = wvec;
            bus_val = '1;
        end else if (wr_clr) begin
            touch   = wvec;
            bus_val = '0;
        end else if (wr_tgl) begin
            touch   = wvec;
            bus_val = ~out_q;
        end
    end

    // A clearing write and a new edge in the same cycle leave the flag set.
    always_comb begin
        event_d = (event_q & ~(wr_event ? wvec : '0)) | rise_vec | fall_vec;
    end

    for (genvar i = 0; i < NR_CH; i++) begin : g_ch
        localparam int unsigned G = i / DATA_W;
        localparam int unsigned B = i % DATA_W;

        logic               out_bit, out_d;
        logic [PULSE_W-1:0] cnt_q, cnt_d;

        assign gmask[i] = (grp == G);
        assign wvec[i]  = (grp == G) && bus_wdata[B];

        user_gpio_evt_filt #(.FILT_W(FILT_W)) u_filt (
            .clk       (clk),
            .nReset    (nReset),
            .din       (virtual_in[i]),
            .filter_len(filter_q),
            .rise_en   (rise_en_q[i]),
            .fall_en   (fall_en_q[i]),
            .level     (filt_vec[i]),
            .rise      (rise_vec[i]),
            .fall      (fall_vec[i])
        );

        // Bus write beats expiry; a zero length turns the set into a plain level.
        always_comb begin
            out_d = out_bit;
            cnt_d = cnt_q;
            if (touch[i]) begin
                out_d = bus_val[i];
                cnt_d = bus_val[i] ? pulse_len_q : '0;
            end else if (cnt_q == PULSE_W'(1)) begin
                out_d = 1'b0;
                cnt_d = '0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - PULSE_W'(1);
            end
        end

        always_ff @(posedge clk or negedge nReset) begin
            if (!nReset) begin
                out_bit <= 1'b0;
                cnt_q   <= '0;
            end else begin
                out_bit <= out_d;
                cnt_q   <= cnt_d;
            end
        end

        assign out_q[i] = out_bit;
    end

    always_comb begin
        rd_vec    = '0;
        rd_scalar = '0;
        if (reg_ok) begin
            case (reg_sel)
                REG_IN:        rd_vec = filt_vec;
                REG_OUT:       rd_vec = out_q;
                REG_RISE_EN:   rd_vec = rise_en_q;
                REG_FALL_EN:   rd_vec = fall_en_q;
                REG_EVENT:     rd_vec = event_q;
                REG_IRQ_MASK:  rd_vec = mask_q;
                REG_FILTER:    if (grp == 0) rd_scalar = DATA_W'(filter_q);
                REG_PULSE_LEN: if (grp == 0) rd_scalar = DATA_W'(pulse_len_q);
                default:       rd_vec = '0;
            endcase
        end
    end

    // Group select for read data; bits past the last channel are tied low.
    for (genvar b = 0; b < DATA_W; b++) begin : g_rbit
        logic [NR_GRP-1:0] col;
        for (genvar g = 0; g < NR_GRP; g++) begin : g_rgrp
            localparam int unsigned GI = g;
            if (g * DATA_W + b < NR_CH) begin : g_used
                assign col[g] = (grp == GI) && rd_vec[g * DATA_W + b];
            end else begin : g_pad
                assign col[g] = 1'b0;
            end
        end
        assign rd_bus[b] = |col;
    end

    assign rdata_c     = rd_bus | rd_scalar;
    assign virtual_out = out_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            bus_rdata    <= '0;
            bus_rd_valid <= 1'b0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            event_q      <= '0;
            mask_q       <= '0;
            filter_q     <= FILT_W'(FILTER_RST);
            pulse_len_q  <= PULSE_W'(PULSE_RST);
            irq          <= 1'b0;
        end else begin
            bus_rd_valid <= bus_rd;
            bus_rdata    <= bus_rd ? rdata_c : '0;
            if (wr_rise) rise_en_q <= (rise_en_q & ~gmask) | wvec;
            if (wr_fall) fall_en_q <= (fall_en_q & ~gmask) | wvec;
            if (wr_mask) mask_q    <= (mask_q & ~gmask) | wvec;
            if (wr_filter) filter_q <= bus_wdata[FILT_W-1:0];
            if (wr_pulse) pulse_len_q <= bus_wdata[PULSE_W-1:0];
            event_q <= event_d;
            irq     <= |(event_q & mask_q);
        end
    end

endmodule

// File: doc/user_gpio_evt.md
# user_gpio_evt

Parametrised successor to the plain user GPIO plugin: a register-mapped GPIO user plugin for the SCU DIOB2 blackbox with a generic channel count and three additions:
- per-channel input glitch filtering and edge-event latching with a masked interrupt;
- atomic set/clear/toggle output access;
- an optional one-shot pulse output mode.

It sits behind a flex-bus slave port of the plugin's secondary bus, between the virtual IO matrix and software.

## Interface
- NR_CH, 48: number of GPIO channels, 1..256
- DATA_W, 32: bus data width
- ADDR_W, 8: bus word-address width; must hold 11*NR_GRP
- FILT_W, 8: glitch-filter counter width
- PULSE_W, 16: pulse-length counter width
- Derived: NR_GRP = ceildiv(NR_CH, DATA_W)
- clk  in  1  system clock; one clock; all logic on rising edge
- nReset  in  1  asynchronous, active-low reset
- bus_addr  in  ADDR_W  word address = reg_idx*NR_GRP + grp
- bus_wr  in  1  write strobe, single cycle
- bus_rd  in  1  read strobe, single cycle; never together with bus_wr
- bus_wdata  in  DATA_W  write data
- bus_rdata  out  DATA_W  read data, valid with bus_rd_valid, else 0
- bus_rd_valid  out  1  one-cycle read acknowledge
- virtual_in  in  NR_CH  asynchronous channel inputs
- virtual_out  out  NR_CH  channel outputs, registered
- irq  out  1  level interrupt, registered

## Operation
Register indices. Each register is NR_GRP words; bit b of group g maps to channel g*DATA_W+b. Bits at or above NR_CH read 0 and ignore writes.
- 0 IN (RO): filtered input level.
- 1 OUT (RW): output register.
- 2 OUT_SET (W1S).
- 3 OUT_CLR (W1C).
- 4 OUT_TGL (W1T).
- 5 RISE_EN (RW): enable rising-edge events.
- 6 FALL_EN (RW): enable falling-edge events.
- 7 EVENT (RO, W1C): sticky event flags.
- 8 IRQ_MASK (RW).
- 9 FILTER (RW): global filter length; group 0 only, low FILT_W bits.
- 10 PULSE_LEN (RW): global pulse length; group 0 only, low PULSE_W bits.
- Indices 2-4 and unmapped addresses read 0. Writes to unmapped addresses are ignored.

Input path, per channel:
- 2-FF synchroniser into sync.
- Filter counter: cleared whenever sync equals filt. Otherwise it increments; when it reaches FILTER, filt takes sync and the counter clears.
- FILTER=0: filt follows sync one cycle later.
- Edge: rise = filt_next & ~filt & RISE_EN; fall likewise with FALL_EN. Either sets EVENT.
- A W1C and a new edge on the same bit in the same cycle: EVENT stays 1 (the event wins).

Output path:
- Writes to OUT, SET, CLR and TGL update OUT in the same cycle.
- PULSE_LEN=0 (level mode): virtual_out = OUT.
- PULSE_LEN=N>0 (pulse mode): any write that takes an OUT bit 0->1 loads that channel's counter with N. The bit clears by itself when the counter expires, giving exactly N cycles high.
- A write that clears the bit aborts the pulse.
- A write that re-sets a bit already high reloads the counter (retrigger).
- A bus write and expiry in the same cycle: the bus write wins.
- Changing PULSE_LEN does not affect pulses already running.

irq = |(EVENT & IRQ_MASK) across all groups, registered.

## Timing
- Reset values:
  - All registers and counters 0; FILTER = 4; PULSE_LEN = 0.
  - virtual_out, irq, bus_rdata and bus_rd_valid are 0.
- Read latency: bus_rd in cycle t gives bus_rd_valid and bus_rdata in t+1.
- Write effect: a write in cycle t is visible in registers at t+1 and on virtual_out at t+1.
- Input-to-EVENT latency: 2 (sync) + FILTER+1 (filter) + 1 (EVENT) cycles.
- EVENT-to-irq: 1 cycle.
- A pulse started at cycle t is high on virtual_out for cycles t+1 .. t+N.
- nReset is asynchronous at any point, including mid-pulse or mid-filter: immediate return to reset values, no residual pulse.

## Structure
- Package user_gpio_evt_pkg holds:
  - the register index enum (REG_IN .. REG_PULSE_LEN);
  - NR_REGS = 11;
  - the reset constants FILTER_RST = 4 and PULSE_RST = 0.
- Sub-module user_gpio_evt_filt: one channel's synchroniser, filter counter and edge detect, instantiated NR_CH times via generate.
- Top level holds the register file, the address decode (reg_idx = addr / NR_GRP, grp = addr % NR_GRP) and the pulse counters.

## Test plan
- Reset then read every register, NR_CH=48, DATA_W=32:
  - all read 0 except FILTER=4;
  - group-1 bits 16..31 read 0 after a write of all-ones.
- FILTER=3, RISE_EN[5]=1, 2-cycle glitch on virtual_in[5]: EVENT stays 0. A held high level sets EVENT[5] exactly 2+4+1 cycles after the edge. With IRQ_MASK[5]=1, irq rises 1 cycle later.
- EVENT W1C of bit 5 in the same cycle as a new edge on ch5: EVENT[5] remains 1 and irq remains 1.
- OUT=0x0F, then SET 0x30, CLR 0x03, TGL 0x81: OUT reads 0x0F, then 0x3F, then 0x3C, then 0xBD; virtual_out matches one cycle after each write.
- PULSE_LEN=10, SET ch40 (group 1, bit 8): virtual_out[40] is high for exactly 10 cycles. A retrigger SET at cycle 6 extends the pulse to cycle 16. A CLR at cycle 3 of a fresh pulse ends it at once.
- nReset asserted mid-pulse and mid-filter count: virtual_out and irq are 0 immediately. After release, there is no pulse and no spurious event.
